// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b ALU operation codes and iterative ALU state encoding
package lc3b_types;

    typedef enum logic [3:0] {
        alu_add  = 4'd0,
        alu_and  = 4'd1,
        alu_not  = 4'd2,
        alu_pass = 4'd3,
        alu_sll  = 4'd4,
        alu_srl  = 4'd5,
        alu_sra  = 4'd6,
        alu_mul  = 4'd7
    } lc3b_aluop;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2,
        DONE  = 2'd3
    } lc3b_alu_state_t;

endpackage

// File: rtl/lc3b_alu_step.sv
// rtl/lc3b_alu_step.sv - one iteration of a shift or (with LC3B_ITER_ALU_MUL_EN) a shift-add multiply
module lc3b_alu_step
    import lc3b_types::*;
#(
    parameter int WIDTH = 16
) (
    input  lc3b_aluop          op,
    input  logic [WIDTH-1:0]   acc,
`ifdef LC3B_ITER_ALU_MUL_EN
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [WIDTH-1:0]   mcand_nx,
    output logic [WIDTH-1:0]   mplier_nx,
`endif
    output logic [WIDTH-1:0]   acc_nx
);

    always_comb begin
        acc_nx = acc;
        case (op)
            alu_sll: acc_nx = {acc[WIDTH-2:0], 1'b0};
            alu_srl: acc_nx = {1'b0, acc[WIDTH-1:1]};
            alu_sra: acc_nx = {acc[WIDTH-1], acc[WIDTH-1:1]};
`ifdef LC3B_ITER_ALU_MUL_EN
            // acc holds the partial product; the multiplicand walks left as the multiplier drains right
            alu_mul: acc_nx = acc + (mplier[0] ? mcand : '0);
`endif
            default: acc_nx = acc;
        endcase
    end

`ifdef LC3B_ITER_ALU_MUL_EN
    assign mcand_nx  = {mcand[WIDTH-2:0], 1'b0};
    assign mplier_nx = {1'b0, mplier[WIDTH-1:1]};
`endif

endmodule

// File: rtl/lc3b_iter_alu.sv
// rtl/lc3b_iter_alu.sv - multi-cycle LC-3b ALU with valid/ready handshake; LC3B_ITER_ALU_MUL_EN adds alu_mul
module lc3b_iter_alu
    import lc3b_types::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         aluop,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               resp_valid,
    output logic [WIDTH-1:0]   resp_data,
    input  logic               resp_ready,
    output logic               busy
);

    // One extra bit so the counter can hold WIDTH for the multiply
    localparam int CNT_W = SHAMT_W + 1;

    lc3b_alu_state_t  state_q, state_d;
    lc3b_aluop        op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d, acc_nx;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef LC3B_ITER_ALU_MUL_EN
    logic [WIDTH-1:0] mcand_q, mcand_d, mcand_nx;
    logic [WIDTH-1:0] mplier_q, mplier_d, mplier_nx;
`endif

    lc3b_alu_step #(.WIDTH(WIDTH)) u_step (
        .op        (op_q),
        .acc       (acc_q),
`ifdef LC3B_ITER_ALU_MUL_EN
        .mcand     (mcand_q),
        .mplier    (mplier_q),
        .mcand_nx  (mcand_nx),
        .mplier_nx (mplier_nx),
`endif
        .acc_nx    (acc_nx)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
`ifdef LC3B_ITER_ALU_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = lc3b_aluop'(aluop);
                    state_d = DONE;
                    case (lc3b_aluop'(aluop))
                        alu_add: res_d = a + b;
                        alu_and: res_d = a & b;
                        alu_not: res_d = ~a;
                        alu_sll, alu_srl, alu_sra: begin
                            acc_d = a;
                            cnt_d = CNT_W'(b[SHAMT_W-1:0]);
                            if (b[SHAMT_W-1:0] == '0) begin
                                res_d = a;
                            end else begin
                                state_d = SHIFT;
                            end
                        end
`ifdef LC3B_ITER_ALU_MUL_EN
                        alu_mul: begin
                            acc_d    = '0;
                            mcand_d  = a;
                            mplier_d = b;
                            cnt_d    = CNT_W'(WIDTH);
                            state_d  = MUL;
                        end
`endif
                        default: res_d = a;
                    endcase
                end
            end
            SHIFT, MUL: begin
                acc_d = acc_nx;
                cnt_d = cnt_q - 1'b1;
`ifdef LC3B_ITER_ALU_MUL_EN
                mcand_d  = mcand_nx;
                mplier_d = mplier_nx;
`endif
                if (cnt_q == CNT_W'(1)) begin
                    res_d   = acc_nx;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= alu_add;
            acc_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
`ifdef LC3B_ITER_ALU_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
`ifdef LC3B_ITER_ALU_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
`endif
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign busy       = (state_q == SHIFT) || (state_q == MUL);
    assign resp_data  = res_q;

endmodule

// File: tb/tb_lc3b_iter_alu.sv
// tb/tb_lc3b_iter_alu.sv - randomized self-checking bench for lc3b_iter_alu against a behavioural model
module tb_lc3b_iter_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  aluop;
    logic [15:0] a;
    logic [15:0] b;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        resp_ready;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lc3b_iter_alu dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .aluop      (aluop),
        .a          (a),
        .b          (b),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_result(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        int sh;
        int unsigned prod;
        sh = int'(y[3:0]);
        case (op)
            4'd0: return x + y;
            4'd1: return x & y;
            4'd2: return ~x;
            4'd4: return x << sh;
            4'd5: return x >> sh;
            4'd6: return 16'($signed(x) >>> sh);
`ifdef LC3B_ITER_ALU_MUL_EN
            4'd7: begin
                prod = int'(x) * int'(y);
                return prod[15:0];
            end
`endif
            default: return x;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [15:0] y);
        if (op == 4'd4 || op == 4'd5 || op == 4'd6) return int'(y[3:0]) + 1;
`ifdef LC3B_ITER_ALU_MUL_EN
        if (op == 4'd7) return 17;
`endif
        return 1;
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] x,
                          input logic [15:0] y, input int hold);
        logic [15:0] exp;
        int lat;
        int busy_cycles;
        exp = ref_result(op, x, y);
        @(negedge clk);
        check({tag, ":req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        aluop     = op;
        a         = x;
        b         = y;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        aluop     = 4'($urandom);
        a         = 16'($urandom);
        b         = 16'($urandom);
        lat         = 1;
        busy_cycles = 0;
        while (!resp_valid && lat < 60) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ":latency"}, 32'(lat), 32'(ref_latency(op, y)));
        check({tag, ":busy_cycles"}, 32'(busy_cycles), 32'(ref_latency(op, y) - 1));
        check({tag, ":resp_data"}, 32'(resp_data), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(posedge clk);
            #1;
            check({tag, ":hold_data"}, 32'(resp_data), 32'(exp));
            check({tag, ":hold_rdy"}, {30'd0, req_ready, resp_valid}, 32'd1);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, ":post_state"}, {30'd0, req_ready, resp_valid}, 32'd2);
        check({tag, ":post_data"}, 32'(resp_data), 32'(exp));
    endtask

    initial begin
        logic [3:0] rop;
        rst        = 1'b1;
        req_valid  = 1'b0;
        aluop      = 4'd0;
        a          = 16'd0;
        b          = 16'd0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset", {13'd0, req_ready, resp_valid, busy, resp_data}, {13'd0, 3'b100, 16'h0000});

        run_op("add_wrap", 4'd0, 16'hFFFF, 16'h0002, 0);
        run_op("sra3", 4'd6, 16'h8000, 16'h0003, 0);
        run_op("sll15", 4'd4, 16'h0001, 16'h000F, 0);
        run_op("srl0", 4'd5, 16'h1234, 16'h0000, 0);
        run_op("and_hold", 4'd1, 16'h0F0F, 16'h00FF, 5);
        run_op("mul", 4'd7, 16'h0123, 16'h0010, 1);
        run_op("undef", 4'd12, 16'hBEEF, 16'h0005, 0);

        // reset during the second SHIFT cycle of srl by 8
        @(negedge clk);
        req_valid = 1'b1;
        aluop     = 4'd5;
        a         = 16'hA5A5;
        b         = 16'h0008;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid", {13'd0, req_ready, resp_valid, busy, resp_data}, {13'd0, 3'b100, 16'h0000});
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("rst_quiet", 32'(resp_valid), 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 9));
            run_op("rand", rop, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
